// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latencies, counter width.
// Build macro MD_MADD_EN enables the multiply-accumulate op (md_op=6).
package md_defs;

    localparam int MD_CNT_W           = 4;
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

`ifdef MD_MADD_EN
    localparam bit MD_MADD_ON = 1'b1;
`else
    localparam bit MD_MADD_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    // Ops that occupy the unit for several cycles and write HI/LO at completion.
    function automatic logic md_is_calc(input logic [2:0] op);
        logic r;
        case (md_op_e'(op))
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
            MD_MADD:                            r = MD_MADD_ON;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (md_op_e'(op) == MD_DIV) || (md_op_e'(op) == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_core.sv
// Combinational multiply/divide datapath: produces the HI/LO result for one calc op.
// Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
module md_core
    import md_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_valid
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] acc;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    always_comb begin
        prod_s = $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
        prod_u = {32'd0, opa} * {32'd0, opb};
        acc    = {hi, lo} + prod_s;

        a_neg    = opa[31];
        b_neg    = opb[31];
        div_zero = (opb == 32'd0);
        a_mag    = a_neg ? (32'd0 - opa) : opa;
        b_mag    = b_neg ? (32'd0 - opb) : opb;

        q_mag = div_zero ? 32'd0 : (a_mag / b_mag);
        r_mag = div_zero ? 32'd0 : (a_mag % b_mag);
        q_u   = div_zero ? 32'd0 : (opa / opb);
        r_u   = div_zero ? 32'd0 : (opa % opb);

        // Quotient truncates toward zero; remainder follows the dividend's sign.
        q_s = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r_s = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_valid = 1'b0;
        case (md_op_e'(op))
            MD_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_valid        = 1'b1;
            end
            MD_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_valid        = 1'b1;
            end
            MD_DIV: begin
                res_hi    = r_s;
                res_lo    = q_s;
                res_valid = !div_zero;
            end
            MD_DIVU: begin
                res_hi    = r_u;
                res_lo    = q_u;
                res_valid = !div_zero;
            end
            MD_MADD: begin
                {res_hi, res_lo} = acc;
                res_valid        = MD_MADD_ON;
            end
            default: begin
                res_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: HI/LO registers, busy counter and stall request.
// MADD (md_op=6) exists only when built with MD_MADD_EN.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;
    logic [31:0]         res_hi_q, res_hi_d;
    logic [31:0]         res_lo_q, res_lo_d;
    logic                res_valid_q, res_valid_d;

    logic [31:0] core_hi;
    logic [31:0] core_lo;
    logic        core_valid;
    logic        accept;
    logic        calc_go;

    md_core u_core (
        .op        (md_op),
        .opa       (opa),
        .opb       (opb),
        .hi        (hi_q),
        .lo        (lo_q),
        .res_hi    (core_hi),
        .res_lo    (core_lo),
        .res_valid (core_valid)
    );

    // A start while busy is dropped; the hazard unit never issues one.
    always_comb begin
        accept  = start && (cnt_q == '0);
        calc_go = accept && md_is_calc(md_op);
    end

    always_comb begin
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        res_valid_d = res_valid_q;

        if (calc_go) begin
            cnt_d       = md_is_div(md_op) ? DIV_LOAD : MULT_LOAD;
            res_hi_d    = core_hi;
            res_lo_d    = core_lo;
            res_valid_d = core_valid;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == MD_CNT_W'(1) && res_valid_q) begin
                hi_d = res_hi_q;
                lo_d = res_lo_q;
            end
        end

        if (accept && (md_op_e'(md_op) == MD_MTHI)) begin
            hi_d = opa;
        end
        if (accept && (md_op_e'(md_op) == MD_MTLO)) begin
            lo_d = opa;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            res_hi_q    <= 32'd0;
            res_lo_q    <= 32'd0;
            res_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        busy      = (cnt_q != '0);
        stall_req = busy || (start && md_is_calc(md_op));
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide execution unit in the EX stage of the pipelined MIPS CPU.
- Responder for the instruction classes mcalc (mult/multu/div/divu/madd), mt (mthi/mtlo) and mf (mfhi/mflo). The front-end decode drives these; this block consumes them.
- Holds the architectural HI/LO registers and models multi-cycle latency with a busy counter.
- Drives stall_req to the hazard unit so that dependent mf/mt/mcalc instructions wait in ID.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  qualifies md_op/opa/opb this cycle (EX holds an mcalc or mt instruction)
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 reserved
- opa  input  32  rs value (forwarded)
- opb  input  32  rt value (forwarded)
- busy  output  1  operation in flight
- stall_req  output  1  busy | (start & md_op in {0,1,2,3,6}), combinational
- hi  output  32  HI register (mfhi source)
- lo  output  32  LO register (mflo source)

Behaviour:
- One clock, clk. Reset is synchronous and active-high (reset): hi=0, lo=0, busy=0, counter=0, shadow regs=0.
- Internals: 4-bit counter cnt; busy = (cnt != 0); shadow {res_hi, res_lo}; flag res_valid.
- Accept rule: start is honoured only when cnt==0. A start while busy is ignored entirely. Requests are never queued; the hazard unit guarantees no such start.
- MULT/MULTU/MADD/DIV/DIVU accepted at edge E:
  - Result is computed from opa/opb sampled at E and stored into the shadow regs.
  - cnt loads MULT_CYCLES or DIV_CYCLES; busy is high for exactly that many cycles after E.
  - hi/lo update on the edge where cnt goes 1->0; busy falls on the same edge.
  - With MULT_CYCLES=5: start sampled at edge 0, busy high during cycles 1..5, hi/lo new after edge 5.
- MTHI/MTLO accepted at edge E: hi (resp. lo) = opa after E. No busy; the other register is unchanged.
- Arithmetic:
  - MULT: signed 32x32->64, {hi,lo}=product.
  - MULTU: unsigned 32x32->64.
  - DIV: signed, quotient truncated toward zero. lo=quotient, hi=remainder carrying the dividend's sign. 0x80000000/-1 gives lo=0x80000000, hi=0.
  - DIVU: unsigned.
  - Divide by zero: still busy DIV_CYCLES; hi/lo left unchanged at completion (res_valid=0).
- MADD: {hi,lo} += signed(opa)*signed(opb), mod 2^64. The accumulate base is the hi/lo value at completion time; it is safe because hi/lo cannot change while busy.
- md_op=7 with start: no effect, no busy.
- Reset mid-operation: the operation is aborted, cnt=0, hi/lo=0, and no late write occurs.
- mf reads hi/lo combinationally at any time. Values read while busy are the old values; the stall prevents this case.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: md_op=6 performs MADD as above.
- Undefined: md_op=6 behaves as reserved (no busy, no write), and stall_req is not asserted for it.

Decomposition:
- Package md_defs: md_op encodings (MD_MULT..MD_MADD), default cycle counts, counter width.
- Sub-module md_core: purely combinational. Takes op, opa, opb, hi, lo and returns {res_hi, res_lo, res_valid}.
- md_unit holds the counter, shadow regs, HI/LO and stall logic.

Test Plan:
- Reset, then MTHI opa=0x12345678 and MTLO opa=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0 one edge later; busy never high.
- MULT opa=0xFFFFFFFF(-1), opb=7 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF9. MULTU with the same operands -> hi=0x00000006, lo=0xFFFFFFF9.
- DIV opa=-7, opb=2 -> busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU opa=7, opb=0 -> busy 10 cycles, hi/lo unchanged.
- MULT in flight, second start (MULT) at cycle 2 -> ignored; first result only; stall_req high through cycle 5.
- Reset asserted at cycle 3 of a DIV -> busy=0, hi=lo=0 next edge; no write at the original completion cycle.
- With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, MADD 1*1 -> after 5 cycles hi=1, lo=0. Without MD_MADD_EN: hi/lo unchanged, busy stays 0.
